// File: rtl/uart_word_assembler.sv
// Packs consecutive UART receiver bytes into 32-bit words and hands them out
// over a valid/ready port with a running word address and stale-byte timeout.
module uart_word_assembler #(
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CLKS = 4000,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              clear,
  output logic [31:0]       word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [ADDR_W-1:0] word_addr,
  output logic              overrun,
  output logic              timeout_tick
);

  localparam int TMR_W = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

  logic [1:0]       byte_cnt;
  logic [23:0]      partial;
  logic [TMR_W-1:0] timer;
  out_state_t       state;

  logic word_done;
  logic xfer;
  logic timer_expire;

  // Drops byte idx (0..2) into its lane of the 24-bit partial register.
  function automatic logic [23:0] place_byte(input logic [23:0] cur,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [23:0] r;
    r = cur;
    if (MSB_FIRST) begin
      case (idx)
        2'd0:    r[23:16] = b;
        2'd1:    r[15:8]  = b;
        default: r[7:0]   = b;
      endcase
    end else begin
      case (idx)
        2'd0:    r[7:0]   = b;
        2'd1:    r[15:8]  = b;
        default: r[23:16] = b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] final_word(input logic [23:0] p,
                                             input logic [7:0]  b);
    return MSB_FIRST ? {p, b} : {b, p};
  endfunction

  assign word_done    = rx_done_tick && (byte_cnt == 2'd3);
  assign xfer         = (state == FULL) && word_ready;
  assign timer_expire = (TIMEOUT_CLKS > 0) && (byte_cnt != 2'd0) &&
                        !rx_done_tick && (timer == TMR_LAST);
  assign word_valid   = (state == FULL);

  // Byte collector and inter-byte timer; an arriving byte always beats expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= 2'd0;
      partial      <= 24'd0;
      timer        <= '0;
      timeout_tick <= 1'b0;
    end else if (clear) begin
      byte_cnt     <= 2'd0;
      timer        <= '0;
      timeout_tick <= 1'b0;
    end else begin
      timeout_tick <= 1'b0;
      if (rx_done_tick) begin
        byte_cnt <= byte_cnt + 2'd1;
        timer    <= '0;
        if (byte_cnt != 2'd3)
          partial <= place_byte(partial, byte_cnt, rx_data);
      end else if (byte_cnt == 2'd0) begin
        timer <= '0;
      end else if (timer_expire) begin
        byte_cnt     <= 2'd0;
        timer        <= '0;
        timeout_tick <= 1'b1;
      end else if (TIMEOUT_CLKS > 0) begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  // Output register: a completed word is only taken when the slot is empty
  // or being emptied on the same edge; otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      word_data <= 32'd0;
      word_addr <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= EMPTY;
      word_addr <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (word_done) begin
            word_data <= final_word(partial, rx_data);
            state     <= FULL;
          end
        end
        FULL: begin
          if (xfer) begin
            word_addr <= word_addr + ADDR_W'(1);
            if (word_done)
              word_data <= final_word(partial, rx_data);
            else
              state <= EMPTY;
          end else if (word_done) begin
            overrun <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
